// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the load/store path.
//   F3_*        : funct3 width/sign codes for loads and stores
//   lsu_state_t : lsu sequencing states
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane extraction / extension for loads and lane merge for sub-word stores.
// Purely combinational.
//   funct3     : width/sign code of the access
//   addr_lo    : byte offset within the word
//   mem_rd     : word read from dmem
//   wdata      : right-aligned store data
//   load_data  : selected lane, sign- or zero-extended
//   merge_data : mem_rd with the addressed lane replaced by store data
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_rd,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = mem_rd[7:0];
    case (addr_lo)
      2'd0: lane_b = mem_rd[7:0];
      2'd1: lane_b = mem_rd[15:8];
      2'd2: lane_b = mem_rd[23:16];
      2'd3: lane_b = mem_rd[31:24];
      default: lane_b = mem_rd[7:0];
    endcase
    lane_h = addr_lo[1] ? mem_rd[31:16] : mem_rd[15:0];

    load_data = mem_rd;
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'h0, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'h0, lane_h};
      default: load_data = mem_rd;
    endcase

    merge_data = mem_rd;
    case (funct3)
      F3_B: begin
        case (addr_lo)
          2'd0: merge_data[7:0]   = wdata[7:0];
          2'd1: merge_data[15:8]  = wdata[7:0];
          2'd2: merge_data[23:16] = wdata[7:0];
          2'd3: merge_data[31:24] = wdata[7:0];
          default: merge_data = mem_rd;
        endcase
      end
      F3_H: begin
        if (addr_lo[1]) merge_data[31:16] = wdata[15:0];
        else            merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between execute and a word-only dmem. One request at a
// time; sub-word stores become read-modify-write; sub-word loads extended.
//   clk, reset                  : clock, synchronous active-low reset
//   req_valid/req_ready         : request handshake
//   req_we/funct3/addr/wdata    : request fields
//   rsp_valid/rsp_ready         : response handshake
//   rsp_rdata/rsp_err           : response payload
//   mem_a/mem_we/mem_wd/mem_rd  : dmem port (combinational read)
//
// state  | meaning
// IDLE   | waiting for a request
// ACCESS | dmem addressed: load captured, SW written, SB/SH word read
// WRITE  | merged word written back for SB/SH
// RESP   | response presented until rsp_ready
module lsu
  import riscv_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  lsu_state_t  state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_wdata;

  logic        f3_ok;
  logic        misaligned;
  logic        out_of_range;
  logic        req_bad;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign req_ready = reset && (state == IDLE);

  always_comb begin
    if (req_we)
      f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    else
      f3_ok = (req_funct3 == F3_B)  || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
              (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    // funct3[1:0] distinguishes width for both signed and unsigned codes
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr[31:2] >= 30'(MEM_WORDS));
    req_bad      = !f3_ok || misaligned || out_of_range;
  end

  lsu_align u_align (
    .funct3     (r_funct3),
    .addr_lo    (r_addr_lo),
    .mem_rd     (mem_rd),
    .wdata      (r_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      r_we      <= 1'b0;
      r_funct3  <= 3'b000;
      r_addr_lo <= 2'b00;
      r_wdata   <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      mem_a     <= 32'h0;
      mem_we    <= 1'b0;
      mem_wd    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_funct3  <= req_funct3;
            r_addr_lo <= req_addr[1:0];
            r_wdata   <= req_wdata;
            rsp_rdata <= 32'h0;
            rsp_err   <= req_bad;
            if (req_bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= ACCESS;
              mem_a <= {req_addr[31:2], 2'b00};
              // SW needs no read, so the write happens during ACCESS itself
              if (req_we && (req_funct3 == F3_W)) begin
                mem_we <= 1'b1;
                mem_wd <= req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (r_we && (r_funct3 != F3_W)) begin
            state  <= WRITE;
            mem_we <= 1'b1;
            mem_wd <= merge_data;
          end else begin
            if (!r_we) rsp_rdata <= load_data;
            state     <= RESP;
            rsp_valid <= 1'b1;
            mem_we    <= 1'b0;
            mem_a     <= 32'h0;
            mem_wd    <= 32'h0;
          end
        end
        WRITE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          mem_we    <= 1'b0;
          mem_a     <= 32'h0;
          mem_wd    <= 32'h0;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
